radix4_divider_32b: RTL and testbench

Iterative radix-4 integer divider, the inverse arithmetic block to the team's 2-bit-slice LUT multiplier. It retires two quotient bits per clock by comparing the partial remainder against a precomputed table of divisor multiples {d, 2d, 3d}. It implements RISC-V DIV/DIVU/REM/REMU semantics behind a start/busy/valid handshake, for use as the divide unit beside the multiplier in the picorv32 coprocessor path.

---
 rtl/radix4_divider_32b.sv | 187 ++++++++++++++++++
 tb/tb_radix4_divider_32b.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/radix4_divider_32b.sv
// Iterative radix-4 restoring divider with RISC-V DIV/DIVU/REM/REMU semantics.
// Two quotient bits per clock; fixed latency of WIDTH/2 + 2 edges from start to valid.
module radix4_divider_32b #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             start,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             valid,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);
    localparam int N  = WIDTH / 2;
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam int RW = WIDTH + 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2
    } state_t;

    state_t state_reg, state_next;

    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] q_reg;
    logic [WIDTH-1:0] r_reg;
    logic [WIDTH-1:0] raw_dividend_reg;
    logic [RW-1:0]    mult_reg [1:3];
    logic             q_neg_reg;
    logic             r_neg_reg;
    logic             zero_reg;
    logic [CW-1:0]    iter_reg;

    logic [WIDTH-1:0] quotient_reg;
    logic [WIDTH-1:0] remainder_reg;
    logic             valid_reg;
    logic             div_by_zero_reg;

    // Operand conditioning: magnitudes and sign flags, only meaningful when signed.
    logic             dividend_neg;
    logic             divisor_neg;
    logic [WIDTH-1:0] a_abs;
    logic [WIDTH-1:0] b_abs;
    logic [RW-1:0]    b_x1;
    logic [RW-1:0]    b_x2;

    assign dividend_neg = is_signed & dividend[WIDTH-1];
    assign divisor_neg  = is_signed & divisor[WIDTH-1];
    assign a_abs        = dividend_neg ? -dividend : dividend;
    assign b_abs        = divisor_neg  ? -divisor  : divisor;
    assign b_x1         = {2'b00, b_abs};
    assign b_x2         = {1'b0, b_abs, 1'b0};

    // Digit selection against the precomputed multiples {b, 2b, 3b}.
    logic [RW-1:0]    r_shift;
    logic [3:1]       ge;
    logic [1:0]       digit;
    logic [RW-1:0]    sub;
    logic [RW-1:0]    r_diff;
    logic [WIDTH-1:0] r_next;
    logic             unused_r_diff_hi;

    assign r_shift = {r_reg, a_reg[WIDTH-1 -: 2]};

    generate
        for (genvar gi = 1; gi <= 3; gi++) begin : g_cmp
            assign ge[gi] = (r_shift >= mult_reg[gi]);
        end
    endgenerate

    always_comb begin
        digit = 2'd0;
        sub   = '0;
        if (ge[3]) begin
            digit = 2'd3;
            sub   = mult_reg[3];
        end else if (ge[2]) begin
            digit = 2'd2;
            sub   = mult_reg[2];
        end else if (ge[1]) begin
            digit = 2'd1;
            sub   = mult_reg[1];
        end
    end

    // The new remainder is always below b, so the top two bits are zero.
    assign r_diff           = r_shift - sub;
    assign r_next           = r_diff[WIDTH-1:0];
    assign unused_r_diff_hi = |r_diff[RW-1:WIDTH];

    // State register
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (start) state_next = CALC;
            CALC:    if (iter_reg == CW'(N - 1)) state_next = FIX;
            FIX:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        busy = (state_reg == CALC) || (state_reg == FIX);
    end

    // Datapath
    always_ff @(posedge clk) begin
        if (!resetn) begin
            a_reg            <= '0;
            q_reg            <= '0;
            r_reg            <= '0;
            raw_dividend_reg <= '0;
            mult_reg[1]      <= '0;
            mult_reg[2]      <= '0;
            mult_reg[3]      <= '0;
            q_neg_reg        <= 1'b0;
            r_neg_reg        <= 1'b0;
            zero_reg         <= 1'b0;
            iter_reg         <= '0;
            quotient_reg     <= '0;
            remainder_reg    <= '0;
            valid_reg        <= 1'b0;
            div_by_zero_reg  <= 1'b0;
        end else begin
            valid_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        a_reg            <= a_abs;
                        raw_dividend_reg <= dividend;
                        q_neg_reg        <= dividend_neg ^ divisor_neg;
                        r_neg_reg        <= dividend_neg;
                        zero_reg         <= (divisor == '0);
                        mult_reg[1]      <= b_x1;
                        mult_reg[2]      <= b_x2;
                        mult_reg[3]      <= b_x1 + b_x2;
                        r_reg            <= '0;
                        q_reg            <= '0;
                        iter_reg         <= '0;
                    end
                end
                CALC: begin
                    a_reg    <= a_reg << 2;
                    r_reg    <= r_next;
                    q_reg    <= {q_reg[WIDTH-3:0], digit};
                    iter_reg <= iter_reg + CW'(1);
                end
                FIX: begin
                    valid_reg <= 1'b1;
                    if (zero_reg) begin
                        quotient_reg    <= '1;
                        remainder_reg   <= raw_dividend_reg;
                        div_by_zero_reg <= 1'b1;
                    end else begin
                        // Negation wraps, which yields the required MIN/-1 overflow result.
                        quotient_reg    <= q_neg_reg ? -q_reg : q_reg;
                        remainder_reg   <= r_neg_reg ? -r_reg : r_reg;
                        div_by_zero_reg <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign valid       = valid_reg;
    assign quotient    = quotient_reg;
    assign remainder   = remainder_reg;
    assign div_by_zero = div_by_zero_reg;

endmodule

// File: tb/tb_radix4_divider_32b.sv
// Self-checking bench for radix4_divider_32b: directed cases, handshake/reset
// scenarios and randomized operands against a plain-arithmetic reference.
module tb_radix4_divider_32b;
    logic        clk = 1'b0;
    logic        resetn;
    logic        start;
    logic        is_signed;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic        busy;
    logic        valid;
    logic [31:0] quotient;
    logic [31:0] remainder;
    logic        div_by_zero;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    radix4_divider_32b #(.WIDTH(32)) dut (
        .clk        (clk),
        .resetn     (resetn),
        .start      (start),
        .is_signed  (is_signed),
        .dividend   (dividend),
        .divisor    (divisor),
        .busy       (busy),
        .valid      (valid),
        .quotient   (quotient),
        .remainder  (remainder),
        .div_by_zero(div_by_zero)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // RISC-V division rules expressed with native arithmetic.
    function automatic void model(input logic [31:0] dd, input logic [31:0] dv, input logic sg,
                                  output logic [31:0] q, output logic [31:0] r, output logic z);
        int sdd;
        int sdv;
        sdd = dd;
        sdv = dv;
        if (dv == 32'd0) begin
            q = 32'hFFFF_FFFF;
            r = dd;
            z = 1'b1;
        end else begin
            z = 1'b0;
            if (sg && dd == 32'h8000_0000 && dv == 32'hFFFF_FFFF) begin
                q = 32'h8000_0000;
                r = 32'd0;
            end else if (sg) begin
                q = sdd / sdv;
                r = sdd % sdv;
            end else begin
                q = dd / dv;
                r = dd % dv;
            end
        end
    endfunction

    task automatic issue(input logic [31:0] dd, input logic [31:0] dv, input logic sg);
        @(negedge clk);
        dividend  = dd;
        divisor   = dv;
        is_signed = sg;
        start     = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    // Counts edges after T0 until valid is seen; optionally pokes a start mid-run
    // (at sample index poke_at) and/or chains a new start into the valid cycle.
    task automatic wait_result(input int poke_at, input bit chain,
                               input logic [31:0] cdd, input logic [31:0] cdv, input logic csg,
                               output int lat, output int busy_cnt,
                               output logic [31:0] q, output logic [31:0] r, output logic z);
        bit v;
        v        = 1'b0;
        lat      = -1;
        busy_cnt = 0;
        q        = '0;
        r        = '0;
        z        = 1'b0;
        for (int k = 0; k < 40 && !v; k++) begin
            @(negedge clk);
            v = valid;
            q = quotient;
            r = remainder;
            z = div_by_zero;
            if (busy) busy_cnt++;
            if (k == poke_at) begin
                start     = 1'b1;
                dividend  = 32'd9;
                divisor   = 32'd2;
                is_signed = 1'b0;
            end else if (k == poke_at + 1) begin
                start = 1'b0;
            end
            if (v && chain) begin
                dividend  = cdd;
                divisor   = cdv;
                is_signed = csg;
                start     = 1'b1;
            end
            @(posedge clk);
            if (v) lat = k + 1;
            if (v && chain) #1 start = 1'b0;
        end
    endtask

    task automatic check_result(input logic [31:0] dd, input logic [31:0] dv, input logic sg,
                                input int lat, input int bc,
                                input logic [31:0] q, input logic [31:0] r, input logic z,
                                input logic [31:0] eq, input logic [31:0] er, input logic ez);
        check("latency", 32'(lat), 32'd18);
        check("busy_cycles", 32'(bc), 32'd17);
        check("quotient", q, eq);
        check("remainder", r, er);
        check("div_by_zero", {31'd0, z}, {31'd0, ez});
        $display("op %h / %h signed=%0b -> q=%h r=%h dbz=%0b latency=%0d", dd, dv, sg, q, r, z, lat);
    endtask

    task automatic run_op(input logic [31:0] dd, input logic [31:0] dv, input logic sg,
                          input logic [31:0] eq, input logic [31:0] er, input logic ez);
        int lat;
        int bc;
        logic [31:0] q;
        logic [31:0] r;
        logic z;
        issue(dd, dv, sg);
        wait_result(-1, 1'b0, 32'd0, 32'd0, 1'b0, lat, bc, q, r, z);
        check_result(dd, dv, sg, lat, bc, q, r, z, eq, er, ez);
        @(negedge clk);
        check("valid_single_pulse", {31'd0, valid}, 32'd0);
    endtask

    initial begin
        int lat;
        int bc;
        int vcount;
        logic [31:0] q;
        logic [31:0] r;
        logic z;
        logic [31:0] dd;
        logic [31:0] dv;
        logic sg;
        logic [31:0] eq;
        logic [31:0] er;
        logic ez;

        resetn    = 1'b0;
        start     = 1'b1;
        is_signed = 1'b0;
        dividend  = 32'd100;
        divisor   = 32'd7;
        repeat (3) @(posedge clk);
        #1;
        check("reset_busy", {31'd0, busy}, 32'd0);
        check("reset_valid", {31'd0, valid}, 32'd0);
        check("reset_quotient", quotient, 32'd0);
        check("reset_remainder", remainder, 32'd0);
        check("reset_dbz", {31'd0, div_by_zero}, 32'd0);
        @(negedge clk);
        resetn = 1'b1;
        start  = 1'b0;
        @(posedge clk);
        #1 check("start_during_reset_ignored", {31'd0, busy}, 32'd0);

        run_op(32'd100, 32'd7, 1'b0, 32'd14, 32'd2, 1'b0);
        run_op(32'hFFFF_FF9C, 32'd7, 1'b1, 32'hFFFF_FFF2, 32'hFFFF_FFFE, 1'b0);
        run_op(32'd100, 32'hFFFF_FFF9, 1'b1, 32'hFFFF_FFF2, 32'd2, 1'b0);
        run_op(32'h0000_1234, 32'd0, 1'b0, 32'hFFFF_FFFF, 32'h0000_1234, 1'b1);
        run_op(32'h0000_1234, 32'd0, 1'b1, 32'hFFFF_FFFF, 32'h0000_1234, 1'b1);
        run_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'h8000_0000, 32'd0, 1'b0);
        run_op(32'hFFFF_FFFF, 32'd3, 1'b0, 32'h5555_5555, 32'd0, 1'b0);

        // Ignored start while busy, then a start chained into the valid cycle.
        issue(32'd100, 32'd7, 1'b0);
        wait_result(4, 1'b1, 32'd9, 32'd2, 1'b0, lat, bc, q, r, z);
        check_result(32'd100, 32'd7, 1'b0, lat, bc, q, r, z, 32'd14, 32'd2, 1'b0);
        wait_result(-1, 1'b0, 32'd0, 32'd0, 1'b0, lat, bc, q, r, z);
        check_result(32'd9, 32'd2, 1'b0, lat, bc, q, r, z, 32'd4, 32'd1, 1'b0);

        // Reset in the middle of an operation.
        issue(32'd1000, 32'd3, 1'b0);
        repeat (7) @(posedge clk);
        @(negedge clk);
        resetn = 1'b0;
        @(posedge clk);
        #1;
        check("midreset_busy", {31'd0, busy}, 32'd0);
        check("midreset_valid", {31'd0, valid}, 32'd0);
        check("midreset_quotient", quotient, 32'd0);
        check("midreset_remainder", remainder, 32'd0);
        @(negedge clk);
        resetn = 1'b1;
        vcount = 0;
        repeat (25) begin
            @(negedge clk);
            if (valid) vcount++;
        end
        check("no_valid_after_reset", 32'(vcount), 32'd0);
        $display("reset mid-operation: valid pulses afterwards=%0d", vcount);
        run_op(32'd50, 32'd5, 1'b0, 32'd10, 32'd0, 1'b0);

        for (int n = 0; n < 40; n++) begin
            dd = $urandom;
            sg = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 4))
                0: dv = $urandom;
                1: dv = 32'($urandom_range(1, 15));
                2: dv = -32'($urandom_range(1, 15));
                3: dv = 32'd0;
                default: begin
                    dd = 32'h8000_0000;
                    dv = 32'hFFFF_FFFF;
                end
            endcase
            model(dd, dv, sg, eq, er, ez);
            run_op(dd, dv, sg, eq, er, ez);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
